vga_sync: RTL

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator with a clk-to-pixel divider.
//
// Parameters
//   PIX_DIV                      clk cycles per pixel (2..16)
//   H_DISP/H_FP/H_SYNC/H_BP      horizontal timing, in pixels
//   V_DISP/V_FP/V_SYNC/V_BP      vertical timing, in lines
// Ports
//   clk         in   system clock (single clock domain)
//   reset       in   asynchronous active-low reset
//   sync_en     in   count enable; low freezes all timing state
//   hsync       out  horizontal sync, active-low, registered
//   vsync       out  vertical sync, active-low, registered
//   video_on    out  visible-area flag, combinational decode of the counters
//   p_tick      out  one-clk pulse per pixel period, registered
//   pixel_x     out  horizontal counter, 0..H_TOTAL-1
//   pixel_y     out  line counter, 0..V_TOTAL-1
//   frame_tick  out  one-clk pulse on the last pixel of a frame, registered
module vga_sync #(
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned DIV_W    = 4;
  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_DISP + H_FP;
  localparam int unsigned HS_LAST  = H_DISP + H_FP + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_DISP + V_FP;
  localparam int unsigned VS_LAST  = V_DISP + V_FP + V_SYNC - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] y_d;
  logic             adv_c;
  logic             p_tick_d;
  logic             frame_tick_d;
  logic             hsync_d;
  logic             vsync_d;

  // Pixel boundary: the registered p_tick is only ever high with the divider
  // at its last value, so gating it with sync_en gives the advance edge.
  assign adv_c = sync_en & p_tick;

  // Next-state divider and counters.
  always_comb begin
    div_d = div_q;
    x_d   = pixel_x;
    y_d   = pixel_y;
    if (sync_en) begin
      if (adv_c) begin
        div_d = '0;
      end else if (div_q != DIV_LAST) begin
        div_d = div_q + DIV_W'(1);
      end
      // Divider parked at its last value after a pause re-arms p_tick for
      // one clk, so the pixel boundary is never taken without a pulse.
    end
    if (adv_c) begin
      if (pixel_x == H_LAST) begin
        x_d = '0;
        y_d = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
      end else begin
        x_d = pixel_x + CNT_W'(1);
      end
    end
  end

  // Output decodes from next-state values so registers line up with counters.
  always_comb begin
    p_tick_d     = sync_en & (div_d == DIV_LAST);
    frame_tick_d = p_tick_d & (x_d == H_LAST) & (y_d == V_LAST);
    hsync_d      = ~((x_d >= CNT_W'(HS_FIRST)) && (x_d <= CNT_W'(HS_LAST)));
    vsync_d      = ~((y_d >= CNT_W'(VS_FIRST)) && (y_d <= CNT_W'(VS_LAST)));
  end

  // Timing state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      p_tick     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_q      <= div_d;
      pixel_x    <= x_d;
      pixel_y    <= y_d;
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      p_tick     <= p_tick_d;
      frame_tick <= frame_tick_d;
    end
  end

  // Visible area decoded straight from the registered counters.
  assign video_on = (pixel_x < CNT_W'(H_DISP)) && (pixel_y < CNT_W'(V_DISP));

endmodule
